// File: rtl/if_stage.sv
// if_stage: instruction fetch with a single outstanding imem read, the IF/ID
// pipeline register, a one-entry skid buffer and redirect/flush handling.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_REQ   | imem_req high at pc, waiting for imem_gnt
//   S_WAIT  | request granted, waiting for imem_rvalid
//   S_FULL  | response parked in skid buffer while decode stalls
//   S_DRAIN | flushed request still in flight; its response is discarded
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        id_load_ok;
  logic [31:0] redirect_pc_al;

  assign id_load_ok     = !id_valid || !stall;
  assign redirect_pc_al = redirect_pc & ~32'h0000_0003;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      fetch_pc <= '0;
      id_valid <= 1'b0;
      id_inst  <= '0;
      id_pc    <= '0;
      buf_inst <= '0;
      buf_pc   <= '0;
    end else if (redirect) begin
      // Flush wins over stall; a request still in flight after this edge must be drained.
      pc       <= redirect_pc_al;
      id_valid <= 1'b0;
      case (state)
        S_REQ:   state <= imem_gnt ? S_DRAIN : S_REQ;
        S_WAIT:  state <= imem_rvalid ? S_REQ : S_DRAIN;
        S_FULL:  state <= S_REQ;
        default: state <= imem_rvalid ? S_REQ : S_DRAIN;
      endcase
    end else begin
      if (id_valid && !stall) id_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            fetch_pc <= pc;
            pc       <= pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (id_load_ok) begin
              id_inst  <= imem_rdata;
              id_pc    <= fetch_pc;
              id_valid <= 1'b1;
              state    <= S_REQ;
            end else begin
              buf_inst <= imem_rdata;
              buf_pc   <= fetch_pc;
              state    <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            id_inst  <= buf_inst;
            id_pc    <= buf_pc;
            id_valid <= 1'b1;
            state    <= S_REQ;
          end
        end
        default: begin
          if (imem_rvalid) state <= S_REQ;
        end
      endcase
    end
  end

endmodule
